// File: rtl/spi_controller.sv
// SPI mode-0 initiator: queues 16-bit register-write frames in a small FIFO
// and serialises them MSB first on nCS/SCLK/COPI at a programmable SCLK rate.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [6:0]                  req_addr,
  input  logic [7:0]                  req_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        done,
  output logic                        nCS,
  output logic                        SCLK,
  output logic                        COPI
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  logic [14:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [14:0]      shreg_q, shreg_d;
  logic             ncs_q, ncs_d;
  logic             sclk_q, sclk_d;
  logic             copi_q, copi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             push, pop, div_wrap;
  logic [15:0]      head_frame;

  assign req_ready  = (count_q != FULL_CNT);
  assign push       = req_valid && req_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign div_wrap   = (div_q == DIV_LAST);
  assign head_frame = {1'b1, mem_q[rd_ptr_q]};

  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nCS        = ncs_q;
  assign SCLK       = sclk_q;
  assign COPI       = copi_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_addr, req_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // COPI holds the bit on the wire; shreg holds the 15 bits still to send.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d = head_frame[14:0];
          copi_d  = head_frame[15];
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end else begin
          busy_d  = 1'b0;
        end
      end
      SETUP: begin
        if (div_wrap) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          div_d   = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_wrap) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d  = 1'b0;
            copi_d  = shreg_q[14];
            shreg_d = {shreg_q[13:0], 1'b0};
          end else if (bit_q == 4'd15) begin
            bit_d   = '0;
            ncs_d   = 1'b1;
            copi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            bit_d   = bit_q + 1'b1;
            sclk_d  = 1'b1;
          end
        end
      end
      GAP: begin
        // Two divider periods; bit counter bit 0 marks the second one.
        if (!div_wrap) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (bit_q[0]) begin
            bit_d   = '0;
            busy_d  = (count_q != '0);
            state_d = IDLE;
          end else begin
            bit_d   = 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      ncs_q    <= 1'b1;
      sclk_q   <= 1'b0;
      copi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      ncs_q    <= ncs_d;
      sclk_q   <= sclk_d;
      copi_q   <= copi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: CLK_DIV=4 and CLK_DIV=2 instances, a wire monitor
// per instance that rebuilds frames, and a register-file model of the peripheral.
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n4 = 1'b1, v4 = 1'b0, rdy4, busy4, done4, ncs4, sclk4, copi4;
  logic [6:0] a4 = '0;
  logic [7:0] d4 = '0;
  logic [2:0] cnt4;
  logic       rst_n2 = 1'b1, v2 = 1'b0, rdy2, busy2, done2, ncs2, sclk2, copi2;
  logic [6:0] a2 = '0;
  logic [7:0] d2 = '0;
  logic [2:0] cnt2;

  spi_controller #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .req_valid(v4), .req_ready(rdy4),
    .req_addr(a4), .req_data(d4), .fifo_count(cnt4), .busy(busy4),
    .done(done4), .nCS(ncs4), .SCLK(sclk4), .COPI(copi4)
  );

  spi_controller #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n2), .req_valid(v2), .req_ready(rdy2),
    .req_addr(a2), .req_data(d2), .fifo_count(cnt2), .busy(busy2),
    .done(done2), .nCS(ncs2), .SCLK(sclk2), .COPI(copi2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;
  vec_t tbl [6];

  // Monitor state, index 0 = CLK_DIV 4 instance, 1 = CLK_DIV 2 instance.
  int          bits [2]       = '{0, 0};
  int          runlen [2]     = '{0, 0};
  int          lowlen [2]     = '{0, 0};
  int          highrun [2]    = '{0, 0};
  int          frames_seen [2]= '{0, 0};
  int          done_cnt [2]   = '{0, 0};
  int          falls [2]      = '{0, 0};
  logic [15:0] sh [2]         = '{16'h0, 16'h0};
  logic        pncs [2]       = '{1'b1, 1'b1};
  logic        psclk [2]      = '{1'b0, 1'b0};
  logic [15:0] rx4 [$];
  logic [15:0] rx2 [$];
  logic [7:0]  pregs [5]      = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0};

  task automatic mon(input int k, input logic rst, input logic ncs, input logic sclk,
                     input logic copi, input logic dn, input int cd);
    logic [15:0] f;
    if (dn) done_cnt[k]++;
    if (rst) begin
      if (pncs[k] && !ncs) begin
        falls[k]++;
        if (frames_seen[k] != 0) chk("gap_ncs_high", int'(highrun[k] >= 2*cd+1), 1);
        runlen[k] = 0;
        lowlen[k] = 0;
        bits[k]   = 0;
      end
      if (sclk != psclk[k]) begin
        chk("sclk_edge_ncs_low", int'(!ncs && !pncs[k]), 1);
        chk("sclk_half_period", runlen[k], cd);
        runlen[k] = 0;
        if (sclk) begin
          sh[k] = {sh[k][14:0], copi};
          bits[k]++;
        end
      end
      if (!pncs[k] && ncs && bits[k] == 16) begin
        f = sh[k];
        chk("last_low_phase", runlen[k], cd);
        chk("ncs_low_len", lowlen[k], 33*cd);
        chk("copi_zero_gap", int'(copi), 0);
        chk("done_at_ncs_rise", int'(dn), 1);
        frames_seen[k]++;
        if (k == 0) begin
          rx4.push_back(f);
          if (f[15] && f[14:8] < 7'd5) pregs[int'(f[14:8])] = f[7:0];
        end else begin
          rx2.push_back(f);
        end
      end
    end
    if (!pncs[k] && ncs) begin
      bits[k]    = 0;
      highrun[k] = 0;
    end
    if (ncs) highrun[k]++;
    else begin
      runlen[k]++;
      lowlen[k]++;
    end
    pncs[k]  = ncs;
    psclk[k] = sclk;
  endtask

  always @(negedge clk) begin
    mon(0, rst_n4, ncs4, sclk4, copi4, done4, 4);
    mon(1, rst_n2, ncs2, sclk2, copi2, done2, 2);
  end

  // Entered and left just after a negedge; valid stays high on return.
  task automatic push(input int k, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    if (k == 0) begin v4 = 1'b1; a4 = a; d4 = d; end
    else begin v2 = 1'b1; a2 = a; d2 = d; end
    while (n < 3000 && !(k == 0 ? rdy4 : rdy2)) begin
      @(negedge clk);
      n++;
    end
    chk("push_wait", int'(n < 3000), 1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    while (n < budget && !(k == 0 ? (!busy4 && cnt4 == 3'd0) : (!busy2 && cnt2 == 3'd0))) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", int'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, f0;
    logic [6:0] ra;
    logic [7:0] rd;
    logic [15:0] exp2 [$];

    tbl[0] = '{7'h00, 8'hF0, 16'h80F0};
    tbl[1] = '{7'h00, 8'hA5, 16'h80A5};
    tbl[2] = '{7'h01, 8'h3C, 16'h813C};
    tbl[3] = '{7'h02, 8'hFF, 16'h82FF};
    tbl[4] = '{7'h03, 8'h00, 16'h8300};
    tbl[5] = '{7'h04, 8'h80, 16'h8480};

    #1 rst_n4 = 1'b0; rst_n2 = 1'b0;
    #1;
    chk("rst_ncs", int'(ncs4), 1);
    chk("rst_sclk", int'(sclk4), 0);
    chk("rst_copi", int'(copi4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_ready", int'(rdy4), 1);
    chk("rst_count", int'(cnt4), 0);
    chk("rst_ncs2", int'(ncs2), 1);
    repeat (3) @(negedge clk);
    rst_n4 = 1'b1; rst_n2 = 1'b1;
    @(negedge clk);

    // Single write: nCS falls one edge after the push.
    d0 = done_cnt[0];
    rx4.delete();
    push(0, tbl[0].addr, tbl[0].data);
    v4 = 1'b0;
    chk("ncs_at_push", int'(ncs4), 1);
    chk("count_at_push", int'(cnt4), 1);
    @(negedge clk);
    chk("ncs_fall_n1", int'(ncs4), 0);
    chk("busy_n1", int'(busy4), 1);
    chk("count_n1", int'(cnt4), 0);
    chk("copi_msb_n1", int'(copi4), 1);
    n = 0;
    while (n < 500 && !done4) begin @(negedge clk); n++; end
    chk("done_wait", int'(n < 500), 1);
    chk("ncs_high_at_done", int'(ncs4), 1);
    n = 0;
    while (n < 50 && busy4) begin @(negedge clk); n++; end
    chk("busy_low_delay", n, 8);
    chk("done_one_cycle", int'(done4), 0);
    repeat (2) @(negedge clk);
    chk("single_done_cnt", done_cnt[0] - d0, 1);
    chk("single_rx_cnt", rx4.size(), 1);
    if (rx4.size() > 0) chk("single_frame", int'(rx4[0]), int'(tbl[0].frame));

    // Register writes through the peripheral model.
    rx4.delete();
    for (int i = 1; i < 6; i++) push(0, tbl[i].addr, tbl[i].data);
    v4 = 1'b0;
    wait_idle(0, 3000);
    chk("e2e_rx_cnt", rx4.size(), 5);
    for (int i = 0; i < 5 && i < rx4.size(); i++) chk("e2e_frame", int'(rx4[i]), int'(tbl[i+1].frame));
    for (int i = 1; i < 6; i++) chk("e2e_reg", int'(pregs[int'(tbl[i].addr)]), int'(tbl[i].data));

    // FIFO full: 6th request held with junk on the bus until space opens.
    rx4.delete();
    d0 = done_cnt[0];
    for (int i = 0; i < 5; i++) push(0, tbl[i].addr, tbl[i].data);
    chk("full_count", int'(cnt4), 4);
    chk("full_ready", int'(rdy4), 0);
    a4 = 7'h7F; d4 = 8'h55;
    repeat (10) @(negedge clk);
    chk("full_hold_count", int'(cnt4), 4);
    chk("full_hold_ready", int'(rdy4), 0);
    push(0, tbl[5].addr, tbl[5].data);
    v4 = 1'b0;
    wait_idle(0, 3000);
    chk("full_rx_cnt", rx4.size(), 6);
    for (int i = 0; i < 6 && i < rx4.size(); i++) chk("full_frame", int'(rx4[i]), int'(tbl[i].frame));
    chk("full_done_cnt", done_cnt[0] - d0, 6);

    // Reset mid-frame after five SCLK rises, with two more requests queued.
    push(0, 7'h02, 8'h11);
    push(0, 7'h03, 8'h77);
    push(0, 7'h04, 8'h66);
    v4 = 1'b0;
    n = 0;
    while (n < 500 && bits[0] < 5) begin @(negedge clk); n++; end
    chk("bits5_wait", int'(n < 500), 1);
    #2 rst_n4 = 1'b0;
    #1;
    chk("midrst_ncs", int'(ncs4), 1);
    chk("midrst_sclk", int'(sclk4), 0);
    chk("midrst_copi", int'(copi4), 0);
    chk("midrst_count", int'(cnt4), 0);
    chk("midrst_busy", int'(busy4), 0);
    chk("midrst_ready", int'(rdy4), 1);
    repeat (3) @(negedge clk);
    f0 = falls[0];
    rst_n4 = 1'b1;
    repeat (200) @(negedge clk);
    chk("postrst_no_frame", falls[0] - f0, 0);
    chk("postrst_ncs", int'(ncs4), 1);
    chk("postrst_busy", int'(busy4), 0);
    chk("postrst_count", int'(cnt4), 0);
    chk("postrst_reg2", int'(pregs[2]), 8'hFF);
    chk("postrst_reg3", int'(pregs[3]), 8'h00);
    chk("postrst_reg4", int'(pregs[4]), 8'h80);

    // CLK_DIV=2 sweep with random address/data pairs.
    rx2.delete();
    for (int i = 0; i < 50; i++) begin
      if (i == 0) begin ra = 7'h7F; rd = 8'hFF; end
      else if (i == 1) begin ra = 7'h00; rd = 8'h00; end
      else begin
        ra = 7'($urandom_range(127, 0));
        rd = 8'($urandom_range(255, 0));
      end
      exp2.push_back({1'b1, ra, rd});
      push(1, ra, rd);
    end
    v2 = 1'b0;
    wait_idle(1, 20000);
    chk("sweep_rx_cnt", rx2.size(), 50);
    for (int i = 0; i < 50 && i < rx2.size(); i++) chk("sweep_frame", int'(rx2[i]), int'(exp2[i]));
    chk("sweep_done_cnt", done_cnt[1], 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
